// File: rtl/booth_mac_accumulator.sv
// Dot-product / MAC engine that sits behind the fixed-latency Booth multiplier.
// Issues a burst of operand pairs, tracks them through the multiplier pipeline and saturates the running sum.
module booth_mac_accumulator #(
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 40,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      product,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   received_q, received_d;
  logic [MUL_LAT-1:0] dly_q, dly_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic               handshake;
  logic               tap_hit;
  logic               last_hit;
  logic [ACC_W:0]     sum;

  assign op_ready  = (state_q == ISSUE) && (issued_q < len_q);
  assign handshake = op_valid && op_ready;
  assign tap_hit   = dly_q[MUL_LAT-1] && ((state_q == ISSUE) || (state_q == DRAIN));
  assign last_hit  = tap_hit && ((received_q + ONE) == len_q);

  // One guard bit above the accumulator exposes overflow in either direction.
  assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-32){product[31]}}, product};

  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
  assign acc_valid = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    dly_d      = MUL_LAT'({dly_q, handshake});

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = len;
          acc_d      = '0;
          ovf_d      = 1'b0;
          issued_d   = '0;
          received_d = '0;
          state_d    = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          issued_d = issued_q + ONE;
          if ((issued_q + ONE) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = state_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A product arriving on the tap overrides the issue transition so the final hit always lands in DONE.
    if (tap_hit) begin
      received_d = received_q + ONE;
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        ovf_d = 1'b1;
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (last_hit) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      dly_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      dly_q      <= dly_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Self-checking bench: two accumulator widths share one stimulus stream fed through a behavioural
// two-stage multiplier, and results are compared with a saturating arithmetic reference model.
module tb_booth_mac_accumulator;

  localparam int MUL_LAT = 2;
  localparam int LEN_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              op_valid;
  logic signed [15:0] a, b;
  logic signed [31:0] p1, p2;

  logic              ready40, valid40, busy40, ovf40;
  logic              ready32, valid32, busy32, ovf32;
  logic [39:0]       acc40;
  logic [31:0]       acc32;

  int nAsserts = 0;
  int nFail    = 0;
  int edgeCnt  = 0;

  int     pa[$];
  int     pb[$];
  longint expProds[$];

  always #5 clk = ~clk;

  // Behavioural multiplier: product of the pair sampled at edge E is stable for sampling at E+2.
  always @(posedge clk) begin
    p1 <= a * b;
    p2 <= p1;
  end

  booth_mac_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(40), .LEN_W(LEN_W)) u40 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(ready40), .product(p2), .acc_out(acc40), .acc_valid(valid40),
    .busy(busy40), .overflow(ovf40)
  );

  booth_mac_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(32), .LEN_W(LEN_W)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .op_valid(op_valid),
    .op_ready(ready32), .product(p2), .acc_out(acc32), .acc_valid(valid32),
    .busy(busy32), .overflow(ovf32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edgeCnt++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Saturating dot product of expProds in a signed accumulator of width w.
  task automatic modelAcc(input int w, output longint acc, output bit ovf);
    longint mx;
    longint mn;
    longint s;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -(longint'(1) <<< (w - 1));
    acc = 0;
    ovf = 1'b0;
    foreach (expProds[k]) begin
      s = acc + expProds[k];
      if (s > mx) begin
        acc = mx;
        ovf = 1'b1;
      end else if (s < mn) begin
        acc = mn;
        ovf = 1'b1;
      end else begin
        acc = s;
      end
    end
  endtask

  function automatic int randOperand();
    logic signed [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'sh8000;
      1:       v = 16'sh7fff;
      default: v = 16'($urandom());
    endcase
    return int'(v);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_acc40"},   {24'b0, acc40}, 64'd0);
    checkOutput({tag, "_acc32"},   {32'b0, acc32}, 64'd0);
    checkOutput({tag, "_valid"},   {62'b0, valid40, valid32}, 64'd0);
    checkOutput({tag, "_busy"},    {62'b0, busy40, busy32}, 64'd0);
    checkOutput({tag, "_ovf"},     {62'b0, ovf40, ovf32}, 64'd0);
    checkOutput({tag, "_op_ready"},{62'b0, ready40, ready32}, 64'd0);
  endtask

  // Runs one burst of n pairs from pa/pb, optionally with an op_valid gap and a stray start in ISSUE.
  task automatic applyStimulus(input int n, input int gapAfter, input int gapLen, input bit midStart,
                               output int startEdge, output int validEdge);
    longint e40, e32;
    bit     o40, o32;
    int     i, gaps, budget, lastHs;
    bit     hs;

    expProds.delete();
    for (int k = 0; k < n; k++) expProds.push_back(longint'(pa[k]) * longint'(pb[k]));
    modelAcc(40, e40, o40);
    modelAcc(32, e32, o32);

    start    = 1'b1;
    len      = LEN_W'(n);
    op_valid = 1'b0;
    tick();
    startEdge = edgeCnt;
    start     = 1'b0;
    validEdge = -1;
    lastHs    = startEdge;
    checkOutput("busy_after_start", {62'b0, busy40, busy32}, 64'd3);

    if (n == 0) begin
      validEdge = edgeCnt;
      checkOutput("len0_valid",    {62'b0, valid40, valid32}, 64'd3);
      checkOutput("len0_acc40",    {24'b0, acc40}, 64'd0);
      checkOutput("len0_op_ready", {62'b0, ready40, ready32}, 64'd0);
      tick();
      checkOutput("len0_valid_end", {62'b0, valid40, valid32}, 64'd0);
      checkOutput("len0_busy_end",  {62'b0, busy40, busy32}, 64'd0);
      return;
    end

    i      = 0;
    gaps   = 0;
    budget = 0;
    while (i < n && budget < 1000) begin
      budget++;
      if (midStart && budget == 1) begin
        start = 1'b1;
        len   = 8'd9;
      end else begin
        start = 1'b0;
        len   = LEN_W'(n);
      end
      if (i == gapAfter && gaps < gapLen) begin
        op_valid = 1'b0;
        a        = 16'($urandom());
        b        = 16'($urandom());
        gaps++;
      end else begin
        op_valid = 1'b1;
        a        = 16'(pa[i]);
        b        = 16'(pb[i]);
      end
      checkOutput("op_ready_issue", {62'b0, ready40, ready32}, 64'd3);
      hs = op_valid;
      tick();
      if (hs) begin
        i++;
        lastHs = edgeCnt;
      end
    end
    start = 1'b0;
    len   = LEN_W'(n);

    // Keep offering junk pairs while draining: none of them may be accepted or accumulated.
    for (int k = 0; k < 20; k++) begin
      op_valid = 1'b1;
      a        = 16'($urandom());
      b        = 16'($urandom());
      checkOutput("op_ready_drain", {62'b0, ready40, ready32}, 64'd0);
      if (valid40) begin
        validEdge = edgeCnt;
        break;
      end
      tick();
    end
    op_valid = 1'b0;

    checkOutput("valid_timing", 64'(validEdge), 64'(lastHs + MUL_LAT));
    checkOutput("valid32_align", {63'b0, valid32}, 64'd1);
    checkOutput("acc40", {24'b0, acc40}, {24'b0, e40[39:0]});
    checkOutput("acc32", {32'b0, acc32}, {32'b0, e32[31:0]});
    checkOutput("ovf40", {63'b0, ovf40}, {63'b0, o40});
    checkOutput("ovf32", {63'b0, ovf32}, {63'b0, o32});

    // A start coinciding with DONE must be ignored.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    checkOutput("valid_one_cycle", {62'b0, valid40, valid32}, 64'd0);
    checkOutput("start_in_done_ignored", {62'b0, busy40, busy32}, 64'd0);
    tick();
    checkOutput("acc40_hold", {24'b0, acc40}, {24'b0, e40[39:0]});
    checkOutput("acc32_hold", {32'b0, acc32}, {32'b0, e32[31:0]});
    checkOutput("ovf32_hold", {63'b0, ovf32}, {63'b0, o32});
  endtask

  initial begin
    int s1, v1, s2, v2, sx, vx, n;

    rst_n    = 1'b1;
    start    = 1'b0;
    len      = '0;
    op_valid = 1'b0;
    a        = '0;
    b        = '0;
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] directed dot product, back-to-back pairs");
    pa = '{3, -2, 100, 1234};
    pb = '{5, 7, -100, 1234};
    applyStimulus(4, 99, 0, 1'b0, s1, v1);
    checkOutput("acc40_directed", {24'b0, acc40}, 64'd1512757);

    $display("[TB] same burst with a 3-cycle op_valid gap");
    applyStimulus(4, 2, 3, 1'b0, s2, v2);
    checkOutput("gap_latency_delta", 64'((v2 - s2) - (v1 - s1)), 64'd3);

    $display("[TB] positive saturation");
    pa = '{-32768, -32768, -32768};
    pb = '{-32768, -32768, -32768};
    applyStimulus(3, 99, 0, 1'b0, sx, vx);
    checkOutput("sat_acc32", {32'b0, acc32}, 64'h7fffffff);
    checkOutput("sat_ovf32", {63'b0, ovf32}, 64'd1);
    pa = '{1};
    pb = '{1};
    applyStimulus(1, 99, 0, 1'b0, sx, vx);
    checkOutput("post_sat_acc32", {32'b0, acc32}, 64'd1);

    $display("[TB] negative saturation then recovery from the clamped base");
    pa = '{-32768, -32768, -32768, 32767};
    pb = '{32767, 32767, 32767, 32767};
    applyStimulus(4, 1, 1, 1'b0, sx, vx);

    $display("[TB] zero-length burst");
    applyStimulus(0, 99, 0, 1'b0, sx, vx);

    $display("[TB] start pulsed during ISSUE");
    pa = '{11, -13};
    pb = '{17, 19};
    applyStimulus(2, 99, 0, 1'b1, sx, vx);

    $display("[TB] randomized bursts");
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 12);
      pa.delete();
      pb.delete();
      for (int k = 0; k < n; k++) begin
        pa.push_back(randOperand());
        pb.push_back(randOperand());
      end
      applyStimulus(n, $urandom_range(0, n - 1), $urandom_range(0, 3), 1'b0, sx, vx);
    end

    $display("[TB] reset in the middle of a burst");
    start    = 1'b1;
    len      = 8'd4;
    tick();
    start    = 1'b0;
    op_valid = 1'b1;
    a = 16'sd3;  b = 16'sd5;
    tick();
    a = -16'sd2; b = 16'sd7;
    tick();
    op_valid = 1'b0;
    tick();
    checkOutput("pre_reset_acc40", {24'b0, acc40}, 64'd15);
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("no_valid_after_abort", {62'b0, valid40, valid32}, 64'd0);
    end
    pa = '{-7};
    pb = '{6};
    applyStimulus(1, 99, 0, 1'b0, sx, vx);
    checkOutput("after_reset_acc40", {24'b0, acc40}, {24'b0, 40'hff_ffff_ffd6});

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
